// File: rtl/iterative_shift_unit_pkg.sv
// Shared constants and types for the iterative shift unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iterative_shift_unit_pkg;

  localparam int ISU_DATA_WIDTH      = 32;
  localparam int ISU_SHAMT_WIDTH     = 5;
  localparam int ISU_STAGE_IDX_WIDTH = 3;

  localparam logic SHIFT_OP_SLL = 1'b0;
  localparam logic SHIFT_OP_SRA = 1'b1;

  // Highest stage index; the sequence runs 16, 8, 4, 2, 1.
  localparam logic [ISU_STAGE_IDX_WIDTH-1:0] ISU_FIRST_STAGE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } isu_state_t;

endpackage

// File: rtl/iterative_shift_unit_shift_stage_select.sv
// One power-of-two shift stage (2^index), SLL zero fill or SRA sign fill.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module shift_stage_select
  import iterative_shift_unit_pkg::*;
(
  input  logic [ISU_DATA_WIDTH-1:0]      i_operand,
  input  logic                           i_op,
  input  logic [ISU_STAGE_IDX_WIDTH-1:0] i_stage_idx,
  output logic [ISU_DATA_WIDTH-1:0]      o_shifted
);

  logic       w_sign;
  logic [31:0] w_sll16, w_sll8, w_sll4, w_sll2, w_sll1;
  logic [31:0] w_sra16, w_sra8, w_sra4, w_sra2, w_sra1;
  logic [31:0] w_st16, w_st8, w_st4, w_st2, w_st1;

  // Sign taken from the operand as it stands, so every SRA stage preserves it.
  assign w_sign = i_operand[31];

  assign w_sll16 = {i_operand[15:0], 16'd0};
  assign w_sll8  = {i_operand[23:0], 8'd0};
  assign w_sll4  = {i_operand[27:0], 4'd0};
  assign w_sll2  = {i_operand[29:0], 2'd0};
  assign w_sll1  = {i_operand[30:0], 1'b0};

  assign w_sra16 = {{16{w_sign}}, i_operand[31:16]};
  assign w_sra8  = {{8{w_sign}},  i_operand[31:8]};
  assign w_sra4  = {{4{w_sign}},  i_operand[31:4]};
  assign w_sra2  = {{2{w_sign}},  i_operand[31:2]};
  assign w_sra1  = {w_sign,       i_operand[31:1]};

  // Pick direction for each fixed-amount stage.
  always_comb begin
    w_st16 = w_sll16;
    w_st8  = w_sll8;
    w_st4  = w_sll4;
    w_st2  = w_sll2;
    w_st1  = w_sll1;
    case (i_op)
      SHIFT_OP_SLL: begin
        w_st16 = w_sll16;
        w_st8  = w_sll8;
        w_st4  = w_sll4;
        w_st2  = w_sll2;
        w_st1  = w_sll1;
      end
      SHIFT_OP_SRA: begin
        w_st16 = w_sra16;
        w_st8  = w_sra8;
        w_st4  = w_sra4;
        w_st2  = w_sra2;
        w_st1  = w_sra1;
      end
      default: ;
    endcase
  end

  // 5:1 stage mux; unused indices pass the operand through untouched.
  always_comb begin
    o_shifted = i_operand;
    case (i_stage_idx)
      3'd4:    o_shifted = w_st16;
      3'd3:    o_shifted = w_st8;
      3'd2:    o_shifted = w_st4;
      3'd1:    o_shifted = w_st2;
      3'd0:    o_shifted = w_st1;
      default: o_shifted = i_operand;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multicycle SLL/SRA unit: one power-of-two stage (16,8,4,2,1) per clock.
// Latency: fixed 5 clocks from start edge to the ready pulse, any shamt.
// Backpressure: busy stalls the pipeline; starts while shifting are ignored.
module iterative_shift_unit
  import iterative_shift_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = ISU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ISU_SHAMT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrl_shift,
  input  logic                   shift_op,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   data_resultRDY,
  output logic                   busy
);

  isu_state_t                     r_state;
  logic [DATA_WIDTH-1:0]          r_work;
  logic [SHAMT_WIDTH-1:0]         r_shamt;
  logic                           r_op;
  logic [ISU_STAGE_IDX_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]          r_result;
  logic                           r_rdy;
  logic                           r_busy;

  logic [DATA_WIDTH-1:0]          w_stage_out;
  logic                           w_stage_en;
  logic [DATA_WIDTH-1:0]          w_next_work;

  shift_stage_select u_stage (
    .i_operand   (r_work),
    .i_op        (r_op),
    .i_stage_idx (r_cnt),
    .o_shifted   (w_stage_out)
  );

  // Apply the current stage only when its shamt bit is set.
  assign w_stage_en  = r_shamt[r_cnt];
  assign w_next_work = w_stage_en ? w_stage_out : r_work;

  // Control FSM with all outputs registered; DONE doubles as an idle slot for back-to-back starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_shamt  <= '0;
      r_op     <= SHIFT_OP_SLL;
      r_cnt    <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (ctrl_shift) begin
            r_work  <= data_operandA;
            r_shamt <= ctrl_shiftamt;
            r_op    <= shift_op;
            r_cnt   <= ISU_FIRST_STAGE;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next_work;
          if (r_cnt == '0) begin
            // Last stage result bypasses straight into the output register.
            r_result <= w_next_work;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Bench for iterative_shift_unit: directed table, corner sequences, random ops vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_iterative_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_shift;
  logic        shift_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  iterative_shift_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .shift_op       (shift_op),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a, input logic [4:0] s);
    logic signed [31:0] sa;
    sa = a;
    if (op) return 32'(sa >>> s);
    return a << s;
  endfunction

  // Issue one start and wait (bounded) for the ready pulse; inputs scrambled after the start edge.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [4:0] s,
                        output int lat, output logic busy_ok);
    shift_op      = op;
    data_operandA = a;
    ctrl_shiftamt = s;
    ctrl_shift    = 1'b1;
    tick();
    ctrl_shift    = 1'b0;
    data_operandA = $urandom;
    ctrl_shiftamt = 5'($urandom);
    shift_op      = 1'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    while (!data_resultRDY && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic op, input logic [31:0] a,
                       input logic [4:0] s, input logic [31:0] exp);
    int   lat;
    logic bok;
    run_op(op, a, s, lat, bok);
    check({name, " latency"}, 32'(lat), 32'd5);
    check({name, " result"}, data_result, exp);
    check({name, " busy in ready cycle"}, {31'd0, busy}, 32'd0);
    check({name, " busy while shifting"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] held;
    logic        r_op;
    logic [31:0] r_a;
    logic [4:0]  r_s;
    int          lat;
    logic        bok;
    logic        saw_rdy;

    vecs[0] = '{1'b1, 32'h80000000, 5'd16, 32'hFFFF8000};
    vecs[1] = '{1'b0, 32'h00000001, 5'd31, 32'h80000000};
    vecs[2] = '{1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    vecs[3] = '{1'b1, 32'hF0000000, 5'd0,  32'hF0000000};
    vecs[4] = '{1'b1, 32'h80000001, 5'd5,  32'hFC000000};
    vecs[5] = '{1'b0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};

    reset = 1'b1;
    ctrl_shift = 1'b0;
    shift_op = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    tick();
    tick();
    check("reset result", data_result, 32'h0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].s, vecs[i].exp);
      tick();
      check($sformatf("vec%0d rdy one cycle", i), {31'd0, data_resultRDY}, 32'd0);
    end

    // Result holds while idle.
    held = data_result;
    repeat (3) tick();
    check("idle hold result", data_result, held);
    check("idle busy", {31'd0, busy}, 32'd0);

    // Start during SHIFT is ignored, then back-to-back start from DONE.
    shift_op = 1'b0; data_operandA = 32'h0000000F; ctrl_shiftamt = 5'd4; ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    tick();
    shift_op = 1'b1; data_operandA = 32'hFFFFFFFF; ctrl_shiftamt = 5'd31; ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    lat = 2;
    while (!data_resultRDY && lat < 20) begin
      tick();
      lat++;
    end
    check("ignored start latency", 32'(lat), 32'd5);
    check("ignored start result", data_result, 32'h000000F0);
    do_op("back to back", 1'b0, 32'h00000001, 5'd1, 32'h00000002);
    tick();

    // Async reset mid-shift aborts with no ready pulse.
    shift_op = 1'b1; data_operandA = 32'h80000000; ctrl_shiftamt = 5'd8; ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort result", data_result, 32'h0);
    check("abort busy", {31'd0, busy}, 32'd0);
    saw_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_resultRDY) saw_rdy = 1'b1;
      if (i == 2) reset = 1'b0;
    end
    check("abort no ready", {31'd0, saw_rdy}, 32'd0);
    check("abort result stays 0", data_result, 32'h0);
    do_op("after reset", 1'b0, 32'h00000003, 5'd2, 32'h0000000C);

    // Random ops against the reference model, some issued back-to-back from DONE.
    for (int i = 0; i < 40; i++) begin
      r_op = 1'($urandom);
      r_a  = $urandom;
      r_s  = 5'($urandom);
      if (i % 4 == 0) r_a[31] = 1'b1;
      run_op(r_op, r_a, r_s, lat, bok);
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd5);
      check($sformatf("rand%0d op=%0d a=%08h s=%0d", i, r_op, r_a, r_s), data_result,
            ref_shift(r_op, r_a, r_s));
      check($sformatf("rand%0d busy", i), {31'd0, bok}, 32'd1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
